codigojunto: RTL and testbench

Registered election-result block. Four candidate slots (A–D) each carry a 2-bit candidate ID and a 6-bit vote count. The block selects the candidate with the most votes. An exact tie for the top count is broken by four 2-bit judge ballots. It sits after the vote-tally stage and drives the winner ID plus a "decided by judges" flag to the display/report logic.

---
 rtl/codigojunto_if.sv | 16 +
 rtl/codigojunto.sv | 51 +++++
 tb/tb_codigojunto.sv | 88 ++++++++
 3 files changed

// File: rtl/codigojunto_if.sv
// codigojunto_if: candidate/vote/judge inputs and registered winner outputs of the election block
interface codigojunto_if;
    logic [1:0] A, B, C, D;
    logic [5:0] VA, VB, VC, VD;
    logic [1:0] J1, J2, J3, J4;
    logic [1:0] Candidato1;
    logic       Candidato2;
    modport master (
        output A, B, C, D, VA, VB, VC, VD, J1, J2, J3, J4,
        input  Candidato1, Candidato2
    );
    modport slave (
        input  A, B, C, D, VA, VB, VC, VD, J1, J2, J3, J4,
        output Candidato1, Candidato2
    );
endinterface

// File: rtl/codigojunto.sv
// codigojunto: registered vote-maximum winner with judge-ballot tie-break
module codigojunto (
    input logic         clk,
    input logic         rst_n,
    codigojunto_if.slave bus
);
    logic [5:0] v [4];
    logic [1:0] id [4];
    logic [1:0] j [4];
    logic [5:0] m;
    logic [3:0] tie;
    logic [2:0] cnt [4];
    logic [2:0] best;
    logic [2:0] ntie;
    logic [1:0] win;
    logic       found;
    assign v  = '{bus.VA, bus.VB, bus.VC, bus.VD};
    assign id = '{bus.A, bus.B, bus.C, bus.D};
    assign j  = '{bus.J1, bus.J2, bus.J3, bus.J4};
    always_comb begin
        m = '0;
        ntie = '0;
        win = '0;
        best = '0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) m = v[i] > m ? v[i] : m;
        for (int i = 0; i < 4; i++) begin
            tie[i] = v[i] == m;
            ntie = ntie + {2'b0, tie[i]};
            cnt[i] = '0;
            for (int k = 0; k < 4; k++) cnt[i] = cnt[i] + {2'b0, j[k] == 2'(i)};
        end
        // strict > keeps the lowest-index slot when ballot counts are equal
        for (int i = 0; i < 4; i++) begin
            if (tie[i] && (!found || cnt[i] > best)) begin
                win = 2'(i);
                best = cnt[i];
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Candidato1 <= 2'b00;
            bus.Candidato2 <= 1'b0;
        end else begin
            bus.Candidato1 <= id[win];
            bus.Candidato2 <= ntie > 3'd1;
        end
    end
endmodule

// File: tb/tb_codigojunto.sv
// tb_codigojunto: directed vectors with a queue scoreboard checked by a decoupled monitor
module tb_codigojunto;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_bad = 0;
    logic [2:0] q [$];
    codigojunto_if bus ();
    codigojunto dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got Candidato1=%b Candidato2=%b, expected Candidato1=%b Candidato2=%b",
                     nm, got[2:1], got[0], exp[2:1], exp[0]);
        end
    endtask
    task automatic drive(input logic [7:0] ids, input logic [23:0] vs, input logic [7:0] js);
        {bus.A, bus.B, bus.C, bus.D} = ids;
        {bus.VA, bus.VB, bus.VC, bus.VD} = vs;
        {bus.J1, bus.J2, bus.J3, bus.J4} = js;
    endtask
    task automatic apply(input logic [7:0] ids, input logic [23:0] vs, input logic [7:0] js,
                         input logic [1:0] c1, input logic c2);
        @(negedge clk);
        drive(ids, vs, js);
        q.push_back({c1, c2});
    endtask
    // monitor: one registered result per edge while expectations are pending
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("scoreboard", {bus.Candidato1, bus.Candidato2}, e);
            end
        end
    end
    initial begin
        int w;
        drive({2'd3, 2'd2, 2'd1, 2'd0}, {6'd63, 6'd1, 6'd1, 6'd2}, 8'hE4);
        #2;
        chk("reset_no_clock", {bus.Candidato1, bus.Candidato2}, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_held_edges", {bus.Candidato1, bus.Candidato2}, 3'b000);
        rst_n = 1'b1;
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd17, 6'd15, 6'd15, 6'd53}, {2'd1, 2'd1, 2'd2, 2'd3}, 2'd3, 1'b0);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd17, 6'd53, 6'd53, 6'd10}, {2'd1, 2'd1, 2'd2, 2'd3}, 2'd1, 1'b1);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd40, 6'd5, 6'd5, 6'd40}, {2'd1, 2'd1, 2'd1, 2'd3}, 2'd3, 1'b1);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd0, 6'd0, 6'd0, 6'd0}, {2'd0, 2'd1, 2'd2, 2'd3}, 2'd0, 1'b1);
        apply({2'd3, 2'd2, 2'd1, 2'd0}, {6'd63, 6'd0, 6'd0, 6'd0}, {2'd1, 2'd1, 2'd1, 2'd1}, 2'd3, 1'b0);
        #1;
        chk("hold_before_edge", {bus.Candidato1, bus.Candidato2}, 3'b001);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd10, 6'd10, 6'd10, 6'd10}, {2'd3, 2'd3, 2'd2, 2'd2}, 2'd2, 1'b1);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd63, 6'd63, 6'd0, 6'd0}, {2'd2, 2'd2, 2'd2, 2'd2}, 2'd0, 1'b1);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd5, 6'd62, 6'd63, 6'd63}, {2'd3, 2'd0, 2'd0, 2'd0}, 2'd3, 1'b1);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd0, 6'd0, 6'd0, 6'd1}, {2'd0, 2'd0, 2'd0, 2'd0}, 2'd3, 1'b0);
        apply({2'd2, 2'd2, 2'd1, 2'd1}, {6'd9, 6'd30, 6'd30, 6'd4}, {2'd1, 2'd2, 2'd2, 2'd0}, 2'd1, 1'b1);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd30, 6'd31, 6'd30, 6'd31}, {2'd0, 2'd0, 2'd0, 2'd3}, 2'd3, 1'b1);
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd50, 6'd50, 6'd50, 6'd49}, {2'd1, 2'd2, 2'd3, 2'd3}, 2'd1, 1'b1);
        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) chk("drain_timeout", 3'(q.size()), 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_mid", {bus.Candidato1, bus.Candidato2}, 3'b000);
        @(negedge clk);
        chk("reset_mid_held", {bus.Candidato1, bus.Candidato2}, 3'b000);
        rst_n = 1'b1;
        apply({2'd0, 2'd1, 2'd2, 2'd3}, {6'd1, 6'd2, 6'd3, 6'd2}, {2'd0, 2'd0, 2'd0, 2'd0}, 2'd2, 1'b0);
        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) chk("drain_timeout", 3'(q.size()), 3'b000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
